// File: rtl/tron_fb_pkg.sv
// Shared frame-buffer geometry, colors and helpers for the Tron display path.
// One 16-bit RAM word per 4-bit pixel, row-major at 640 words per line.
package tron_fb_pkg;

    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int FB_WORDS = 307200;
    localparam int FB_AW    = 19;

    typedef enum logic [3:0] {
        BLACK  = 4'h0,
        RED    = 4'h1,
        BLUE   = 4'h2,
        YELLOW = 4'h3,
        WHITE  = 4'hF
    } color_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fbw_state_t;

    // y*640 + x using shifts only: 640 = 512 + 128.
    function automatic logic [FB_AW-1:0] fb_pixel_addr(input logic [9:0] x, input logic [9:0] y);
        logic [FB_AW-1:0] x_w;
        logic [FB_AW-1:0] y_w;
        x_w = {9'd0, x};
        y_w = {9'd0, y};
        return (y_w << 4'd9) + (y_w << 4'd7) + x_w;
    endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Bundle between the bike/game-logic side and the frame RAM write port.
// master = requesters and clear trigger, slave = the write arbiter.
interface fb_write_arbiter_if;
    import tron_fb_pkg::*;

    logic             clear_start;
    logic [1:0]       req;
    logic [9:0]       x0;
    logic [9:0]       x1;
    logic [9:0]       y0;
    logic [9:0]       y1;
    logic [3:0]       color0;
    logic [3:0]       color1;
    logic [1:0]       ack;
    logic             range_err;
    logic             WE;
    logic [FB_AW-1:0] write_address;
    logic [15:0]      Data_In;
    logic             busy;
    logic             clear_done;

    modport master (
        output clear_start, req, x0, x1, y0, y1, color0, color1,
        input  ack, range_err, WE, write_address, Data_In, busy, clear_done
    );

    modport slave (
        input  clear_start, req, x0, x1, y0, y1, color0, color1,
        output ack, range_err, WE, write_address, Data_In, busy, clear_done
    );

endinterface

// File: rtl/fb_clear_seq.sv
// Full-screen clear address counter. cnt_r is the address currently on the bus;
// addr is the next one to issue and last flags the final word while active.
module fb_clear_seq
    import tron_fb_pkg::*;
#(
    parameter int unsigned WORDS = FB_WORDS
)(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             active,
    output logic [FB_AW-1:0] addr,
    output logic             last
);

    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(WORDS - 32'd1);
    localparam logic [FB_AW-1:0] ONE       = 19'd1;

    logic [FB_AW-1:0] cnt_r;

    // Counter: loads zero on start, advances once per clear cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_r <= 19'd0;
        end else if (start) begin
            cnt_r <= 19'd0;
        end else if (active) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign addr = cnt_r + ONE;
    assign last = active && (cnt_r == LAST_ADDR);

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame RAM write-port arbiter: round-robin between two bike writers, with a
// full-screen clear sequence that takes priority and locks the bikes out.
module fb_write_arbiter #(
    parameter int unsigned H_RES       = 32'd640,
    parameter int unsigned V_RES       = 32'd480,
    parameter logic [3:0]  CLEAR_COLOR = 4'h0,
    parameter int unsigned CLEAR_WORDS = tron_fb_pkg::FB_WORDS
)(
    input  logic Clk,
    input  logic Reset,
    fb_write_arbiter_if.slave bus
);
    import tron_fb_pkg::*;

    localparam logic [9:0]  X_LIM      = 10'(H_RES);
    localparam logic [9:0]  Y_LIM      = 10'(V_RES);
    localparam logic [15:0] CLEAR_WORD = {12'h000, CLEAR_COLOR};

    fbw_state_t       state_r;
    fbw_state_t       state_nxt_s;
    logic             ptr_r;
    logic             ptr_nxt_s;
    logic [1:0]       ack_r;
    logic [1:0]       ack_nxt_s;
    logic             we_r;
    logic             we_nxt_s;
    logic [FB_AW-1:0] addr_r;
    logic [FB_AW-1:0] addr_nxt_s;
    logic [15:0]      data_r;
    logic [15:0]      data_nxt_s;
    logic             rerr_r;
    logic             rerr_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             done_r;
    logic             done_nxt_s;

    logic [1:0]       elig_s;
    logic             grant_vld_s;
    logic             grant_idx_s;
    logic [9:0]       sel_x_s;
    logic [9:0]       sel_y_s;
    logic [3:0]       sel_color_s;
    logic             in_range_s;
    logic [FB_AW-1:0] pix_addr_s;

    logic             seq_start_s;
    logic             seq_active_s;
    logic             seq_last_s;
    logic [FB_AW-1:0] seq_addr_s;

    assign seq_start_s  = (state_r == IDLE) && bus.clear_start;
    assign seq_active_s = (state_r == CLEAR);

    fb_clear_seq #(
        .WORDS (CLEAR_WORDS)
    ) u_clear_seq (
        .Clk    (Clk),
        .Reset  (Reset),
        .start  (seq_start_s),
        .active (seq_active_s),
        .addr   (seq_addr_s),
        .last   (seq_last_s)
    );

    // Arbitration: a bike in its ack cycle is not eligible, so a lone requester
    // gets at most every other cycle and two requesters alternate.
    always_comb begin
        elig_s      = bus.req & ~ack_r;
        grant_vld_s = |elig_s;
        if (elig_s == 2'b11) begin
            grant_idx_s = ptr_r;
        end else if (elig_s[1]) begin
            grant_idx_s = 1'b1;
        end else begin
            grant_idx_s = 1'b0;
        end
        if (grant_idx_s) begin
            sel_x_s     = bus.x1;
            sel_y_s     = bus.y1;
            sel_color_s = bus.color1;
        end else begin
            sel_x_s     = bus.x0;
            sel_y_s     = bus.y0;
            sel_color_s = bus.color0;
        end
        in_range_s = (sel_x_s < X_LIM) && (sel_y_s < Y_LIM);
        pix_addr_s = fb_pixel_addr(sel_x_s, sel_y_s);
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r <= IDLE;
            ptr_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Next-state logic; clear_start mid-clear is deliberately not looked at.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.clear_start) begin
                    state_nxt_s = CLEAR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                if (seq_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output logic: next values for the registered RAM port and status pulses.
    always_comb begin
        ack_nxt_s  = 2'b00;
        we_nxt_s   = 1'b0;
        rerr_nxt_s = 1'b0;
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        addr_nxt_s = addr_r;
        data_nxt_s = data_r;
        ptr_nxt_s  = ptr_r;
        case (state_r)
            IDLE: begin
                if (bus.clear_start) begin
                    we_nxt_s   = 1'b1;
                    addr_nxt_s = 19'd0;
                    data_nxt_s = CLEAR_WORD;
                    busy_nxt_s = 1'b1;
                end else if (grant_vld_s) begin
                    ack_nxt_s = grant_idx_s ? 2'b10 : 2'b01;
                    ptr_nxt_s = ~grant_idx_s;
                    if (in_range_s) begin
                        we_nxt_s   = 1'b1;
                        addr_nxt_s = pix_addr_s;
                        data_nxt_s = {12'h000, sel_color_s};
                    end else begin
                        rerr_nxt_s = 1'b1;
                    end
                end else begin
                    ack_nxt_s = 2'b00;
                end
            end
            CLEAR: begin
                if (seq_last_s) begin
                    done_nxt_s = 1'b1;
                end else begin
                    we_nxt_s   = 1'b1;
                    addr_nxt_s = seq_addr_s;
                    data_nxt_s = CLEAR_WORD;
                    busy_nxt_s = 1'b1;
                end
            end
            default: begin
                ack_nxt_s = 2'b00;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ack_r  <= 2'b00;
            we_r   <= 1'b0;
            addr_r <= 19'd0;
            data_r <= 16'h0000;
            rerr_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            ack_r  <= ack_nxt_s;
            we_r   <= we_nxt_s;
            addr_r <= addr_nxt_s;
            data_r <= data_nxt_s;
            rerr_r <= rerr_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    assign bus.ack           = ack_r;
    assign bus.WE            = we_r;
    assign bus.write_address = addr_r;
    assign bus.Data_In       = data_r;
    assign bus.range_err     = rerr_r;
    assign bus.busy          = busy_r;
    assign bus.clear_done    = done_r;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: vector table, a randomized run against
// a behavioural model, and hand-written clear/reset sequences.
module tb_fb_write_arbiter;

    localparam int CW = 1500;
    localparam logic [15:0] CLR_WORD = 16'h000A;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fb_write_arbiter_if bif();

    fb_write_arbiter #(
        .H_RES       (640),
        .V_RES       (480),
        .CLEAR_COLOR (4'hA),
        .CLEAR_WORDS (CW)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bif.slave)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bif.req = 2'b00;
        bif.clear_start = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [9:0]  x0, y0, x1, y1;
        logic [3:0]  c0, c1;
        logic [1:0]  ack;
        logic        we;
        logic        rerr;
        logic [18:0] addr;
        logic [15:0] data;
    } vec_t;

    vec_t vt[8];

    // behavioural model state
    int          m_left;
    int          m_caddr;
    bit          m_done_pend;
    bit          m_ptr;
    logic [1:0]  m_prev_ack;

    initial begin
        logic [1:0]  e_ack;
        logic        e_we, e_rerr, e_busy, e_done;
        logic [18:0] e_addr;
        logic [15:0] e_data;
        logic [1:0]  elig;
        int          g, px, py;
        int          n_we, exp_a;
        bit          fin;

        rst_n = 1'b0;
        bif.clear_start = 1'b0;
        bif.req = 2'b00;
        bif.x0 = 10'd0; bif.y0 = 10'd0; bif.color0 = 4'd0;
        bif.x1 = 10'd0; bif.y1 = 10'd0; bif.color1 = 4'd0;

        // ---------------- reset values ----------------
        tick(); tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("reset_outputs",
                {bif.ack, bif.range_err, bif.WE, bif.busy, bif.clear_done, bif.write_address, bif.Data_In[8:0]},
                32'd0);
        end

        // ---------------- vector table ----------------
        vt[0] = '{2'b01, 10'd3,    10'd2,    10'd0,   10'd0,   4'd4, 4'd0,  2'b01, 1'b1, 1'b0, 19'd1283,   16'h0004};
        vt[1] = '{2'b10, 10'd0,    10'd0,    10'd640, 10'd0,   4'd0, 4'd9,  2'b10, 1'b0, 1'b1, 19'd0,      16'h0000};
        vt[2] = '{2'b10, 10'd0,    10'd0,    10'd639, 10'd479, 4'd0, 4'hF,  2'b10, 1'b1, 1'b0, 19'd307199, 16'h000F};
        vt[3] = '{2'b01, 10'd0,    10'd480,  10'd0,   10'd0,   4'd2, 4'd0,  2'b01, 1'b0, 1'b1, 19'd0,      16'h0000};
        vt[4] = '{2'b01, 10'd0,    10'd0,    10'd0,   10'd0,   4'd1, 4'd0,  2'b01, 1'b1, 1'b0, 19'd0,      16'h0001};
        vt[5] = '{2'b10, 10'd0,    10'd0,    10'd100, 10'd100, 4'd0, 4'd7,  2'b10, 1'b1, 1'b0, 19'd64100,  16'h0007};
        vt[6] = '{2'b01, 10'd1023, 10'd1023, 10'd0,   10'd0,   4'd5, 4'd0,  2'b01, 1'b0, 1'b1, 19'd0,      16'h0000};
        vt[7] = '{2'b01, 10'd639,  10'd0,    10'd0,   10'd0,   4'd3, 4'd0,  2'b01, 1'b1, 1'b0, 19'd639,    16'h0003};

        for (int i = 0; i < 8; i++) begin
            bif.req = vt[i].req;
            bif.x0 = vt[i].x0; bif.y0 = vt[i].y0; bif.color0 = vt[i].c0;
            bif.x1 = vt[i].x1; bif.y1 = vt[i].y1; bif.color1 = vt[i].c1;
            tick();
            chk($sformatf("vec%0d_ack", i), {30'd0, bif.ack}, {30'd0, vt[i].ack});
            chk($sformatf("vec%0d_we_rerr", i), {30'd0, bif.WE, bif.range_err}, {30'd0, vt[i].we, vt[i].rerr});
            if (vt[i].we) begin
                chk($sformatf("vec%0d_addr", i), {13'd0, bif.write_address}, {13'd0, vt[i].addr});
                chk($sformatf("vec%0d_data", i), {16'd0, bif.Data_In}, {16'd0, vt[i].data});
            end
            bif.req = 2'b00;
            tick();
            chk($sformatf("vec%0d_quiet", i), {28'd0, bif.ack, bif.WE, bif.range_err}, 32'd0);
        end

        // ---------------- round-robin from reset pointer ----------------
        do_reset();
        bif.x0 = 10'd10; bif.y0 = 10'd10; bif.color0 = 4'd1;
        bif.x1 = 10'd20; bif.y1 = 10'd20; bif.color1 = 4'd2;
        bif.req = 2'b11;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("alt_ack", {30'd0, bif.ack}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("alt_addr", {13'd0, bif.write_address}, (k % 2 == 0) ? 32'd6410 : 32'd12820);
        end
        bif.req = 2'b00;

        // ---------------- randomized run vs model ----------------
        do_reset();
        m_left = 0; m_caddr = 0; m_done_pend = 1'b0; m_ptr = 1'b0; m_prev_ack = 2'b00;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int b = 0; b < 2; b++) begin
                if (!bif.req[b] || m_prev_ack[b]) begin
                    bif.req[b] = ($urandom_range(0, 3) != 0);
                    if (b == 0) begin
                        bif.x0 = 10'($urandom_range(0, 700));
                        bif.y0 = 10'($urandom_range(0, 520));
                        bif.color0 = 4'($urandom_range(0, 15));
                    end else begin
                        bif.x1 = 10'($urandom_range(0, 700));
                        bif.y1 = 10'($urandom_range(0, 520));
                        bif.color1 = 4'($urandom_range(0, 15));
                    end
                end
            end
            bif.clear_start = ($urandom_range(0, 499) == 0);

            e_ack = 2'b00; e_we = 1'b0; e_rerr = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            e_addr = 19'd0; e_data = 16'h0000;
            if (m_left > 0) begin
                e_we = 1'b1; e_busy = 1'b1; e_addr = 19'(m_caddr); e_data = CLR_WORD;
                m_caddr++; m_left--;
                if (m_left == 0) m_done_pend = 1'b1;
            end else if (m_done_pend) begin
                e_done = 1'b1;
                m_done_pend = 1'b0;
            end else if (bif.clear_start) begin
                e_we = 1'b1; e_busy = 1'b1; e_addr = 19'd0; e_data = CLR_WORD;
                m_caddr = 1; m_left = CW - 1;
            end else begin
                elig = bif.req & ~m_prev_ack;
                g = -1;
                if (elig == 2'b11) g = int'(m_ptr);
                else if (elig[1]) g = 1;
                else if (elig[0]) g = 0;
                if (g >= 0) begin
                    e_ack[g] = 1'b1;
                    m_ptr = (g == 0);
                    px = (g == 1) ? int'(bif.x1) : int'(bif.x0);
                    py = (g == 1) ? int'(bif.y1) : int'(bif.y0);
                    if (px < 640 && py < 480) begin
                        e_we = 1'b1;
                        e_addr = 19'(py * 640 + px);
                        e_data = {12'h000, (g == 1) ? bif.color1 : bif.color0};
                    end else begin
                        e_rerr = 1'b1;
                    end
                end
            end
            m_prev_ack = e_ack;

            tick();
            chk("rnd_ctl", {26'd0, bif.ack, bif.WE, bif.range_err, bif.busy, bif.clear_done},
                           {26'd0, e_ack, e_we, e_rerr, e_busy, e_done});
            if (e_we) begin
                chk("rnd_addr", {13'd0, bif.write_address}, {13'd0, e_addr});
                chk("rnd_data", {16'd0, bif.Data_In}, {16'd0, e_data});
            end
        end
        bif.clear_start = 1'b0;

        // ---------------- clear while bike 0 waits ----------------
        do_reset();
        bif.req = 2'b01;
        bif.x0 = 10'd5; bif.y0 = 10'd5; bif.color0 = 4'd3;
        bif.clear_start = 1'b1;
        tick();
        bif.clear_start = 1'b0;
        chk("clr_first_ctl", {28'd0, bif.ack, bif.WE, bif.busy}, 32'd3);
        chk("clr_first_addr", {13'd0, bif.write_address}, 32'd0);
        chk("clr_first_data", {16'd0, bif.Data_In}, {16'd0, CLR_WORD});
        n_we = 1; exp_a = 1; fin = 1'b0;
        for (int c = 0; c < CW + 10 && !fin; c++) begin
            bif.clear_start = (c == 500);
            tick();
            if (bif.busy) begin
                chk("clr_addr", {13'd0, bif.write_address}, exp_a);
                chk("clr_we_ack", {29'd0, bif.WE, bif.ack}, 32'd4);
                exp_a++; n_we++;
            end else begin
                fin = 1'b1;
            end
        end
        bif.clear_start = 1'b0;
        chk("clr_finished", {31'd0, fin}, 32'd1);
        chk("clr_len", n_we, CW);
        chk("clr_done_cycle", {27'd0, bif.clear_done, bif.WE, bif.busy, bif.ack}, 32'h10);
        tick();
        chk("clr_then_ack", {29'd0, bif.ack, bif.WE}, 32'd3);
        chk("clr_then_addr", {13'd0, bif.write_address}, 32'd3205);
        chk("clr_then_data", {16'd0, bif.Data_In}, 32'h0003);
        chk("clr_done_once", {31'd0, bif.clear_done}, 32'd0);
        bif.req = 2'b00;
        tick();

        // ---------------- reset in the middle of a clear ----------------
        do_reset();
        bif.clear_start = 1'b1;
        tick();
        bif.clear_start = 1'b0;
        for (int c = 0; c < 1100 && bif.write_address != 19'd1000; c++) tick();
        chk("rst_reach_1000", {13'd0, bif.write_address}, 32'd1000);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_clear", {29'd0, bif.WE, bif.busy, bif.clear_done}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_idle_after", {29'd0, bif.WE, bif.busy, bif.clear_done}, 32'd0);
        bif.clear_start = 1'b1;
        tick();
        bif.clear_start = 1'b0;
        chk("restart_ctl", {30'd0, bif.WE, bif.busy}, 32'd3);
        chk("restart_addr0", {13'd0, bif.write_address}, 32'd0);
        tick();
        chk("restart_addr1", {13'd0, bif.write_address}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Write-port controller for the 640x480, 4-bit-per-pixel frame buffer RAM. It shares the single RAM write port between two bike trail writers and an internal full-screen clear sequencer. It converts (x, y, color) pixel requests into linear word writes. It sits between the game-logic bike modules and `frameRAM`; the display read path is untouched.

## Interface
Parameters:
- `H_RES`, 640: pixels per line.
- `V_RES`, 480: lines per frame.
- `CLEAR_COLOR`, 4'h0: color written by the clear sequencer.

Ports:
- `Clk`  in  1  system clock; all logic is on its rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `clear_start`  in  1  single-cycle pulse that starts a full-screen clear.
- `req[1:0]`  in  2  per-bike write request, level, held until acked.
- `x0`, `x1`  in  10  pixel X for bike 0 / bike 1.
- `y0`, `y1`  in  10  pixel Y for bike 0 / bike 1.
- `color0`, `color1`  in  4  pixel color for bike 0 / bike 1.
- `ack[1:0]`  out  2  one-cycle acknowledge per bike.
- `range_err`  out  1  one-cycle pulse when an acked request was out of range.
- `WE`  out  1  frame RAM write enable.
- `write_address`  out  19  frame RAM word address.
- `Data_In`  out  16  frame RAM write data; `{12'h000, color}`.
- `busy`  out  1  high while clearing.
- `clear_done`  out  1  one-cycle pulse after the last clear write.

## Operation
- One word per pixel. Address = y*640 + x, computed as (y<<9)+(y<<7)+x, 19-bit result. The maximum is 307199.
- State machine states: `IDLE`, `CLEAR`.
- **IDLE**
  - `clear_start` moves the block to `CLEAR` and loads the clear counter with 0.
  - `clear_start` wins over any pending `req`. No bike is granted in that cycle.
  - Otherwise, pending bike requests are arbitrated round-robin.
    - One pointer bit names the preferred bike. It flips to the other bike after every grant.
    - The pointer resets to bike 0.
- **Eligibility**: a bike is eligible when its `req` is high and its `ack` is low this cycle. The ack cycle is therefore a dead cycle for that requester.
- Bike protocol: a bike may present a new pixel with `req` still high in the cycle after it sees `ack`.
- **Grant** on the edge where a bike is chosen:
  - `ack[i]` goes high for one cycle.
  - If x < H_RES and y < V_RES: `WE` goes high with that bike's address and data.
  - Otherwise: `WE` stays low and `range_err` pulses.
- **CLEAR**
  - Every cycle: `WE`=1, `write_address`=counter, `Data_In`={12'h0, CLEAR_COLOR}. The counter then increments.
  - After writing address 307199: return to `IDLE` and pulse `clear_done` in the next cycle.
  - `clear_start` received while in `CLEAR` is ignored; the counter does not restart.
  - Bike requests are held off and never acked during `CLEAR`.
  - `busy`=1 for the entire `CLEAR` state.
- Reset mid-clear aborts immediately. The next cycle is `IDLE` with `WE` low; partially cleared RAM contents are left as they are.

## Timing
- All outputs are registered.
- Reset values: `WE`=0, `write_address`=0, `Data_In`=0, `ack`=0, `range_err`=0, `busy`=0, `clear_done`=0, state `IDLE`, pointer=bike 0.
- Request latency: `req` high before edge N produces `ack`/`WE` valid in the cycle after edge N, i.e. one cycle.
- Throughput:
  - One write per cycle overall.
  - Each bike gets at most one grant every 2 cycles.
  - With both bikes continuously requesting, grants alternate 0,1,0,1...
- `WE` is high for exactly one cycle per bike write. The address and data are stable for that cycle.
- Clear duration: `clear_start` at edge N gives `busy`=1 from cycle N+1.
  - `WE` is high for 307200 consecutive cycles.
  - `clear_done` pulses in the cycle after the last write, which is also the first cycle `busy`=0.
  - The first bike grant can appear on the following edge.

## Structure
- Package `tron_fb_pkg` holds:
  - `H_RES`, `V_RES`, `FB_WORDS`=307200, `FB_AW`=19.
  - Color enum `color_t` (4-bit, `BLACK`=0).
  - State typedef `fbw_state_t` {`IDLE`, `CLEAR`}.
- Sub-module `fb_clear_seq` contains the 19-bit clear counter and its last-address detect. Its interface is start, active, addr, last.
- Arbitration and address calculation stay in the top module.

## Test plan
- Reset released with all inputs 0: all outputs hold their reset values for 10 cycles.
- `req[0]` with x0=3, y0=2, color0=4: next cycle `ack`=01, `WE`=1, `write_address`=1283, `Data_In`=16'h0004.
- Both `req` high continuously, pointer at reset: grants run 0,1,0,1 on consecutive cycles. Neither bike is ever acked in two consecutive cycles.
- `req[1]` with x1=640, y1=0: `ack`=10, `range_err`=1, `WE`=0. Separately, x1=639, y1=479 writes address 307199.
- `clear_start` while `req[0]` is held:
  - 307200 cycles of `WE` with addresses 0..307199 in order.
  - `ack` stays 0 throughout.
  - `clear_done` pulses, then bike 0 is acked on the next edge.
  - A second `clear_start` mid-clear has no effect.
- `Reset` asserted at clear address 1000: next cycle `WE`=0, `busy`=0, no `clear_done`. A new `clear_start` then restarts at address 0.
